// File: rtl/arm_mul_unit.sv
// Iterative multiply unit for MUL, MLA, UMULL and SMULL. It retires BITS_PER_CYCLE
// multiplier bits per RUN cycle, applies the sign/accumulate fix-up in FIX and pulses done.
module arm_mul_unit #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 2,
  parameter bit EARLY_TERM     = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               flush,
  input  logic [1:0]         op,
  input  logic               set_flags,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  input  logic [WIDTH-1:0]   acc,
  input  logic [3:0]         nzcv_in,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result_lo,
  output logic [WIDTH-1:0]   result_hi,
  output logic [3:0]         nzcv_out,
  output logic               nzcv_we
);

  localparam int STEPS = WIDTH / BITS_PER_CYCLE;
  localparam int CW    = $clog2(STEPS + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_e;
  typedef enum logic [1:0] {OP_MUL, OP_MLA, OP_UMULL, OP_SMULL} op_e;

  state_e               state_q, state_d;
  op_e                  op_q;
  logic                 sf_q, sign_q;
  logic [1:0]           cv_q;
  logic [WIDTH-1:0]     acc_q, mplier_q;
  logic [2*WIDTH-1:0]   mcand_q, prod_q;
  logic [CW-1:0]        cnt_q;
  logic [WIDTH-1:0]     lo_q, hi_q;
  logic [3:0]           nzcv_q;

  logic                 accept, commit, last_run;
  logic [WIDTH-1:0]     abs_a, abs_b, mplier_nx;
  logic [2*WIDTH-1:0]   pp, fix_p;
  logic [WIDTH-1:0]     fix_lo, fix_hi;
  logic                 fix_n, fix_z;

  // N and Z are computed from the result; only C and V come from the caller.
  logic unused_flags;
  assign unused_flags = ^nzcv_in[3:2];

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    abs_a = op_a;
    abs_b = op_b;
    if (op_e'(op) == OP_SMULL) begin
      if (op_a[WIDTH-1]) abs_a = -op_a;
      if (op_b[WIDTH-1]) abs_b = -op_b;
    end
  end

  // Partial product of the multiplicand with the low multiplier digit.
  always_comb begin
    pp = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (mplier_q[i]) pp = pp + (mcand_q << i);
    end
  end

  assign mplier_nx = mplier_q >> BITS_PER_CYCLE;
  assign last_run  = (cnt_q == CW'(STEPS - 1)) || (EARLY_TERM && (mplier_nx == '0));

  always_comb begin
    fix_p = prod_q;
    if (op_q == OP_SMULL && sign_q) fix_p = -prod_q;
    if (op_q == OP_MLA) fix_p[WIDTH-1:0] = prod_q[WIDTH-1:0] + acc_q;
    fix_lo = fix_p[WIDTH-1:0];
    fix_hi = op_q[1] ? fix_p[2*WIDTH-1:WIDTH] : '0;
    fix_n  = op_q[1] ? fix_hi[WIDTH-1] : fix_lo[WIDTH-1];
    fix_z  = op_q[1] ? ({fix_hi, fix_lo} == '0) : (fix_lo == '0);
  end

  // Flush wins over start in IDLE/DONE and aborts RUN/FIX without a done.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (!flush && start) begin
          accept  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (flush)         state_d = S_IDLE;
        else if (last_run) state_d = S_FIX;
      end
      S_FIX: begin
        if (flush) state_d = S_IDLE;
        else begin
          commit  = 1'b1;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= OP_MUL;
      sf_q     <= 1'b0;
      sign_q   <= 1'b0;
      cv_q     <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      mcand_q  <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
      nzcv_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q     <= op_e'(op);
        sf_q     <= set_flags;
        sign_q   <= (op_e'(op) == OP_SMULL) && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
        cv_q     <= nzcv_in[1:0];
        acc_q    <= acc;
        mcand_q  <= {{WIDTH{1'b0}}, abs_a};
        mplier_q <= abs_b;
        prod_q   <= '0;
        cnt_q    <= '0;
      end else if (state_q == S_RUN) begin
        prod_q   <= prod_q + pp;
        mcand_q  <= mcand_q << BITS_PER_CYCLE;
        mplier_q <= mplier_nx;
        cnt_q    <= cnt_q + CW'(1);
      end
      if (commit) begin
        lo_q   <= fix_lo;
        hi_q   <= fix_hi;
        nzcv_q <= {fix_n, fix_z, cv_q};
      end
    end
  end

  assign busy      = (state_q == S_RUN) || (state_q == S_FIX);
  assign done      = (state_q == S_DONE);
  assign nzcv_we   = done && sf_q;
  assign result_lo = lo_q;
  assign result_hi = hi_q;
  assign nzcv_out  = nzcv_q;

endmodule
